// File: rtl/smart_home_pkg.sv
// Shared encodings and default timing for the smart-home controller channels.
// Used by fire_responder and its beep generator.
package smart_home_pkg;

    typedef enum logic [1:0] {
        FR_IDLE      = 2'd0,
        FR_SOUNDING  = 2'd1,
        FR_SILENCED  = 2'd2,
        FR_ESCALATED = 2'd3
    } fr_state_e;

    localparam int unsigned FR_BEEP_ON        = 4;
    localparam int unsigned FR_BEEP_OFF       = 4;
    localparam int unsigned FR_ESC_TIMEOUT    = 64;
    localparam int unsigned FR_SILENCE_CYCLES = 32;

    // Width of a counter that runs 0..terminal-1, never narrower than one bit.
    function automatic int unsigned fr_cnt_width(input int unsigned terminal);
        return (terminal > 1) ? $clog2(terminal) : 1;
    endfunction

endpackage

// File: rtl/beep_gen.sv
// Siren beep phase counter: synchronous clear and enable, reports whether the
// phase being loaded this edge falls in the audible part of the period.
module beep_gen
    import smart_home_pkg::*;
#(
    parameter int unsigned BEEP_ON  = FR_BEEP_ON,
    parameter int unsigned BEEP_OFF = FR_BEEP_OFF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic level_next
);

    localparam int unsigned PERIOD = BEEP_ON + BEEP_OFF;
    localparam int unsigned PW     = fr_cnt_width(PERIOD);

    logic [PW-1:0] phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        if (clr) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = (phase_q == PW'(PERIOD - 1)) ? '0 : phase_q + 1'b1;
        end
        level_next = (phase_d < PW'(BEEP_ON));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/fire_responder.sv
// Fire-channel alarm responder: beeping siren, ack/silence window and, when
// FIRE_DISPATCH_EN is defined, latched escalation with an external dispatch line.
module fire_responder
    import smart_home_pkg::*;
#(
    parameter int unsigned BEEP_ON        = FR_BEEP_ON,
    parameter int unsigned BEEP_OFF       = FR_BEEP_OFF,
    parameter int unsigned SILENCE_CYCLES = FR_SILENCE_CYCLES
`ifdef FIRE_DISPATCH_EN
    ,
    parameter int unsigned ESC_TIMEOUT    = FR_ESC_TIMEOUT
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       f_alarm,
    input  logic       ack,
    output logic       siren,
    output logic       dispatch,
    output logic [1:0] state
);

    localparam int unsigned SW = fr_cnt_width(SILENCE_CYCLES);

    fr_state_e     state_q, state_d;
    logic          siren_q, siren_d;
    logic [SW-1:0] sil_q, sil_d;
    logic          beep_clr, beep_en, beep_level;

`ifdef FIRE_DISPATCH_EN
    localparam int unsigned EW = fr_cnt_width(ESC_TIMEOUT);

    logic [EW-1:0] esc_q, esc_d;
    logic          dispatch_q, dispatch_d;
`endif

    always_comb begin
        state_d = state_q;
        sil_d   = sil_q;
`ifdef FIRE_DISPATCH_EN
        esc_d   = esc_q;
`endif
        unique case (state_q)
            FR_IDLE: begin
                if (f_alarm) begin
                    state_d = FR_SOUNDING;
`ifdef FIRE_DISPATCH_EN
                    esc_d   = '0;
`endif
                end
            end
            FR_SOUNDING: begin
                if (!f_alarm) begin
                    state_d = FR_IDLE;
                end else if (ack) begin
                    state_d = FR_SILENCED;
                    sil_d   = '0;
`ifdef FIRE_DISPATCH_EN
                end else if (esc_q == EW'(ESC_TIMEOUT - 1)) begin
                    state_d = FR_ESCALATED;
                end else begin
                    esc_d   = esc_q + 1'b1;
`endif
                end
            end
            FR_SILENCED: begin
                if (!f_alarm) begin
                    state_d = FR_IDLE;
                end else if (sil_q == SW'(SILENCE_CYCLES - 1)) begin
                    state_d = FR_SOUNDING;
`ifdef FIRE_DISPATCH_EN
                    esc_d   = '0;
`endif
                end else begin
                    sil_d   = sil_q + 1'b1;
                end
            end
`ifdef FIRE_DISPATCH_EN
            FR_ESCALATED: begin
                // Latched: only an occupant ack after the fire has cleared releases it.
                if (ack && !f_alarm) begin
                    state_d = FR_IDLE;
                end
            end
`endif
            default: state_d = FR_IDLE;
        endcase
    end

    // Phase restarts on every entry into SOUNDING so the first cycle is audible.
    assign beep_clr = (state_d == FR_SOUNDING) && (state_q != FR_SOUNDING);
    assign beep_en  = (state_q == FR_SOUNDING);

    beep_gen #(
        .BEEP_ON  (BEEP_ON),
        .BEEP_OFF (BEEP_OFF)
    ) u_beep_gen (
        .clk        (clk),
        .rst        (rst),
        .clr        (beep_clr),
        .en         (beep_en),
        .level_next (beep_level)
    );

    always_comb begin
        siren_d = (state_d == FR_SOUNDING) && beep_level;
`ifdef FIRE_DISPATCH_EN
        siren_d    = siren_d || (state_d == FR_ESCALATED);
        dispatch_d = (state_d == FR_ESCALATED);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FR_IDLE;
            siren_q    <= 1'b0;
            sil_q      <= '0;
`ifdef FIRE_DISPATCH_EN
            esc_q      <= '0;
            dispatch_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            siren_q    <= siren_d;
            sil_q      <= sil_d;
`ifdef FIRE_DISPATCH_EN
            esc_q      <= esc_d;
            dispatch_q <= dispatch_d;
`endif
        end
    end

    assign siren = siren_q;
    assign state = state_q;
`ifdef FIRE_DISPATCH_EN
    assign dispatch = dispatch_q;
`else
    assign dispatch = 1'b0;
`endif

endmodule

// File: tb/tb_fire_responder.sv
// Scoreboard bench for fire_responder: stimulus queues the expected registered
// outputs for each edge, a monitor compares them #1 after that edge.
module tb_fire_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       f_alarm = 1'b0;
    logic       ack = 1'b0;
    logic       siren;
    logic       dispatch;
    logic [1:0] state;

    fire_responder dut (
        .clk      (clk),
        .rst      (rst),
        .f_alarm  (f_alarm),
        .ack      (ack),
        .siren    (siren),
        .dispatch (dispatch),
        .state    (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic       sr;
        logic       dp;
        int         tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Default 4-on/4-off beep: siren level for SOUNDING cycle k is pat[k % 8].
    logic [7:0] pat = 8'h0F;

    task automatic step(input logic r, input logic f, input logic a,
                        input logic [1:0] st, input logic sr, input logic dp, input int tag);
        @(negedge clk);
        rst     = r;
        f_alarm = f;
        ack     = a;
        exp_q.push_back('{st: st, sr: sr, dp: dp, tag: tag});
    endtask

    task automatic sound(input int k, input int tag);
        step(1'b0, 1'b1, 1'b0, 2'd1, pat[k % 8], 1'b0, tag);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (state !== mon_e.st || siren !== mon_e.sr || dispatch !== mon_e.dp) begin
                errors++;
                $display("FAIL tag %0d: state/siren/dispatch got %0d/%0b/%0b want %0d/%0b/%0b",
                         mon_e.tag, state, siren, dispatch, mon_e.st, mon_e.sr, mon_e.dp);
            end
        end
    end

    initial begin
        // Reset held with alarm present, then release.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1);
        for (int k = 0; k < 20; k++) sound(k, 2);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3);

        // Ack at SOUNDING cycle 10, silence window of 32, then re-sound at phase 0.
        for (int k = 0; k <= 10; k++) sound(k, 4);
        step(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 5);
        for (int i = 0; i < 31; i++) step(1'b0, 1'b1, (i == 15), 2'd2, 1'b0, 1'b0, 6);
        step(1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 7);
        for (int k = 1; k <= 8; k++) sound(k, 8);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 9);

        // Unacknowledged alarm.
        for (int k = 0; k < 64; k++) sound(k, 10);
`ifdef FIRE_DISPATCH_EN
        step(1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 11);
        step(1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 12);
        step(1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 13);
        step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 14);
`else
        for (int k = 64; k < 200; k++) sound(k, 11);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 14);
`endif

        // Ack on the timeout edge wins; then f_alarm drop in SILENCED.
        for (int k = 0; k < 64; k++) sound(k, 15);
        step(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 16);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 17);
        // One-cycle glitch, and ack with alarm drop together in SOUNDING.
        step(1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 18);
        step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 19);
        step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 20);

        // Reset mid-escalation (mid-beep when escalation is not built).
        for (int k = 0; k < 64; k++) sound(k, 21);
`ifdef FIRE_DISPATCH_EN
        step(1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 22);
`endif
        step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 23);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 24);

        // Reset mid-silence window.
        step(1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 25);
        step(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 25);
        step(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 25);
        step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 26);
        step(1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 27);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 28);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending expectations got %0d want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
